// File: rtl/pipe_run_ctrl.sv
// Run controller for the 5-stage MIPS pipeline: fetch enable, HALT detect, watchdog, counters.
// Single-step support (PAUSE/STEP states, i_step_mode/i_step) is built only with PIPE_STEP_EN.
module pipe_run_ctrl #(
   parameter logic [31:0] HALT_INSTR   = 32'h0000000C,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter logic [31:0] MAX_CYCLES   = 32'd100000,
   parameter int unsigned CNT_WIDTH    = 32
) (
   input  logic                 d_clk,
   input  logic                 d_rst,
   input  logic                 i_start,
   input  logic                 i_stop,
   input  logic                 i_step_mode,
   input  logic                 i_step,
   input  logic [31:0]          i_instr,
   input  logic                 i_instr_valid,
   input  logic                 i_stall,
   input  logic                 i_retire,
   output logic                 o_ce,
   output logic                 o_busy,
   output logic                 o_done,
   output logic [1:0]           o_reason,
   output logic [2:0]           o_state,
   output logic [CNT_WIDTH-1:0] o_cycle_cnt,
   output logic [CNT_WIDTH-1:0] o_retired_cnt
);

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StRun   = 3'd1,
      StDrain = 3'd2,
      StDone  = 3'd3,
      StPause = 3'd4,
      StStep  = 3'd5
   } state_e;

   typedef enum logic [1:0] {
      RsnNone    = 2'd0,
      RsnHalt    = 2'd1,
      RsnStop    = 2'd2,
      RsnTimeout = 2'd3
   } reason_e;

   localparam logic [3:0]           DrainLast = 4'(DRAIN_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] WdogLast  = CNT_WIDTH'(MAX_CYCLES - 32'd1);
   localparam logic [CNT_WIDTH-1:0] CntMax    = '1;
   localparam logic [CNT_WIDTH-1:0] CntOne    = CNT_WIDTH'(1);

   state_e               state_q, state_d;
   reason_e              reason_q, reason_d;
   logic [3:0]           drain_q, drain_d;
   logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
   logic [CNT_WIDTH-1:0] retired_q, retired_d;

   logic    clear;
   logic    counting;
   logic    halt_hit;
   logic    timeout;
   logic    step_mode;
   reason_e early;

`ifdef PIPE_STEP_EN
   logic step_pulse;

   assign step_mode  = i_step_mode;
   assign step_pulse = i_step;
`else
   logic unused_step;

   assign step_mode   = 1'b0;
   assign unused_step = i_step_mode ^ i_step;
`endif

   // A HALT held under a load-use stall is only taken once the stall releases.
   assign halt_hit = i_instr_valid && !i_stall && (i_instr == HALT_INSTR);

   always_comb begin
      early = RsnNone;
      if (halt_hit) begin
         early = RsnHalt;
      end else if (i_stop) begin
         early = RsnStop;
      end
   end

`ifdef PIPE_STEP_EN
   // With stepping, the watchdog must see RUN cycles only, not STEP or DRAIN.
   logic [CNT_WIDTH-1:0] wdog_q, wdog_d;

   always_comb begin
      wdog_d = wdog_q;
      if (clear) begin
         wdog_d = '0;
      end else if ((state_q == StRun) && (wdog_q != CntMax)) begin
         wdog_d = wdog_q + CntOne;
      end
   end

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         wdog_q <= '0;
      end else begin
         wdog_q <= wdog_d;
      end
   end

   assign timeout = (wdog_q == WdogLast);
`else
   assign timeout = (cycle_q == WdogLast);
`endif

   always_comb begin
      state_d  = state_q;
      reason_d = reason_q;
      drain_d  = drain_q;
      clear    = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            if (i_start) begin
               state_d  = step_mode ? StPause : StRun;
               reason_d = RsnNone;
               drain_d  = '0;
               clear    = 1'b1;
            end
         end
         StRun: begin
            if (early != RsnNone) begin
               state_d  = StDrain;
               reason_d = early;
               drain_d  = '0;
            end else if (timeout) begin
               state_d  = StDrain;
               reason_d = RsnTimeout;
               drain_d  = '0;
            end else if (step_mode) begin
               state_d = StPause;
            end
         end
         StDrain: begin
            if (drain_q == DrainLast) begin
               state_d = StDone;
            end else begin
               drain_d = drain_q + 4'd1;
            end
         end
`ifdef PIPE_STEP_EN
         StPause: begin
            if (early != RsnNone) begin
               state_d  = StDrain;
               reason_d = early;
               drain_d  = '0;
            end else if (!step_mode) begin
               state_d = StRun;
            end else if (step_pulse) begin
               state_d = StStep;
            end
         end
         StStep: begin
            if (early != RsnNone) begin
               state_d  = StDrain;
               reason_d = early;
               drain_d  = '0;
            end else begin
               state_d = StPause;
            end
         end
`endif
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         state_q  <= StIdle;
         reason_q <= RsnNone;
         drain_q  <= '0;
      end else begin
         state_q  <= state_d;
         reason_q <= reason_d;
         drain_q  <= drain_d;
      end
   end

   assign counting = (state_q == StRun) || (state_q == StStep) || (state_q == StDrain);

   // Both counters saturate so a long run never reads back as a short one.
   always_comb begin
      cycle_d   = cycle_q;
      retired_d = retired_q;
      if (clear) begin
         cycle_d   = '0;
         retired_d = '0;
      end else begin
         if (counting && (cycle_q != CntMax)) begin
            cycle_d = cycle_q + CntOne;
         end
         if (i_retire && o_busy && (retired_q != CntMax)) begin
            retired_d = retired_q + CntOne;
         end
      end
   end

   always_ff @(posedge d_clk or negedge d_rst) begin
      if (!d_rst) begin
         cycle_q   <= '0;
         retired_q <= '0;
      end else begin
         cycle_q   <= cycle_d;
         retired_q <= retired_d;
      end
   end

   assign o_ce          = (state_q == StRun) || (state_q == StStep);
   assign o_busy        = (state_q == StRun) || (state_q == StPause) ||
                          (state_q == StStep) || (state_q == StDrain);
   assign o_done        = (state_q == StDone);
   assign o_reason      = reason_q;
   assign o_state       = state_q;
   assign o_cycle_cnt   = cycle_q;
   assign o_retired_cnt = retired_q;

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Bench for pipe_run_ctrl: directed test-plan scenarios then random traffic, all checked
// every cycle against a behavioural run/drain/done model.
module tb_pipe_run_ctrl;

   localparam logic [31:0] HaltWord = 32'h0000000C;
   localparam logic [31:0] NopWord  = 32'h20080001;
   localparam int          DrainCyc = 4;
   localparam int          MaxCyc   = 20;

   localparam int MIdle  = 0;
   localparam int MRun   = 1;
   localparam int MDrain = 2;
   localparam int MDone  = 3;
   localparam int MPause = 4;
   localparam int MStep  = 5;

`ifdef PIPE_STEP_EN
   localparam bit StepOn = 1'b1;
`else
   localparam bit StepOn = 1'b0;
`endif

   logic        d_clk = 1'b0;
   logic        d_rst = 1'b0;
   logic        i_start = 1'b0;
   logic        i_stop = 1'b0;
   logic        i_step_mode = 1'b0;
   logic        i_step = 1'b0;
   logic [31:0] i_instr = NopWord;
   logic        i_instr_valid = 1'b0;
   logic        i_stall = 1'b0;
   logic        i_retire = 1'b0;
   logic        o_ce, o_busy, o_done;
   logic [1:0]  o_reason;
   logic [2:0]  o_state;
   logic [31:0] o_cycle_cnt, o_retired_cnt;

   int tests = 0;
   int fails = 0;

   // Behavioural model state
   int     m_mode = MIdle;
   int     m_reason = 0;
   int     m_drain_left = 0;
   longint m_cycles = 0;
   longint m_retired = 0;
   longint m_run = 0;

   pipe_run_ctrl #(
      .HALT_INSTR   (HaltWord),
      .DRAIN_CYCLES (DrainCyc),
      .MAX_CYCLES   (32'(MaxCyc)),
      .CNT_WIDTH    (32)
   ) dut (
      .d_clk         (d_clk),
      .d_rst         (d_rst),
      .i_start       (i_start),
      .i_stop        (i_stop),
      .i_step_mode   (i_step_mode),
      .i_step        (i_step),
      .i_instr       (i_instr),
      .i_instr_valid (i_instr_valid),
      .i_stall       (i_stall),
      .i_retire      (i_retire),
      .o_ce          (o_ce),
      .o_busy        (o_busy),
      .o_done        (o_done),
      .o_reason      (o_reason),
      .o_state       (o_state),
      .o_cycle_cnt   (o_cycle_cnt),
      .o_retired_cnt (o_retired_cnt)
   );

   always #5 d_clk = ~d_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mode = MIdle;
      m_reason = 0;
      m_drain_left = 0;
      m_cycles = 0;
      m_retired = 0;
      m_run = 0;
   endtask

   task automatic enter_drain(input int cause);
      m_reason = cause;
      m_mode = MDrain;
      m_drain_left = DrainCyc;
   endtask

   // One clock edge of the run controller, from the rules: end causes by priority,
   // DRAIN lasting DrainCyc cycles, counters cleared on start and frozen otherwise.
   task automatic model_step();
      bit halt;
      int pre;
      halt = i_instr_valid && !i_stall && (i_instr == HaltWord);
      pre = m_mode;
      if (pre == MRun || pre == MStep || pre == MDrain) m_cycles++;
      if (i_retire && pre != MIdle && pre != MDone) m_retired++;
      case (pre)
         MIdle, MDone: begin
            if (i_start) begin
               m_mode = (StepOn && i_step_mode) ? MPause : MRun;
               m_cycles = 0;
               m_retired = 0;
               m_run = 0;
               m_reason = 0;
            end
         end
         MRun: begin
            m_run++;
            if (halt) enter_drain(1);
            else if (i_stop) enter_drain(2);
            else if (m_run >= MaxCyc) enter_drain(3);
            else if (StepOn && i_step_mode) m_mode = MPause;
         end
         MPause: begin
            if (halt) enter_drain(1);
            else if (i_stop) enter_drain(2);
            else if (!i_step_mode) m_mode = MRun;
            else if (i_step) m_mode = MStep;
         end
         MStep: begin
            if (halt) enter_drain(1);
            else if (i_stop) enter_drain(2);
            else m_mode = MPause;
         end
         MDrain: begin
            m_drain_left--;
            if (m_drain_left == 0) m_mode = MDone;
         end
         default: m_mode = MIdle;
      endcase
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".ce"}, 64'(o_ce), 64'(m_mode == MRun || m_mode == MStep));
      chk({tag, ".busy"}, 64'(o_busy), 64'(m_mode != MIdle && m_mode != MDone));
      chk({tag, ".done"}, 64'(o_done), 64'(m_mode == MDone));
      chk({tag, ".reason"}, 64'(o_reason), 64'(m_reason));
      chk({tag, ".state"}, 64'(o_state), 64'(m_mode));
      chk({tag, ".cycles"}, 64'(o_cycle_cnt), 64'(m_cycles));
      chk({tag, ".retired"}, 64'(o_retired_cnt), 64'(m_retired));
   endtask

   task automatic tick(input string tag);
      @(posedge d_clk);
      model_step();
      @(negedge d_clk);
      check_model(tag);
   endtask

   task automatic quiet_inputs();
      i_start = 1'b0;
      i_stop = 1'b0;
      i_step = 1'b0;
      i_instr = NopWord;
      i_instr_valid = 1'b1;
      i_stall = 1'b0;
   endtask

   task automatic run_to_done(input string tag);
      for (int i = 0; i < 3 * MaxCyc; i++) begin
         if (m_mode == MDone) break;
         tick(tag);
      end
      chk({tag, ".reached_done"}, 64'(o_done), 64'd1);
   endtask

   initial begin
      int pulses;
      // Reset state
      #2;
      check_model("reset");
      chk("reset.state0", 64'(o_state), 64'd0);
      @(negedge d_clk);
      d_rst = 1'b1;
      quiet_inputs();
      tick("idle");

      // Halt at cycle 10 of the run
      i_start = 1'b1;
      tick("halt.start");
      i_start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         i_retire = 1'b1;
         tick("halt.run");
      end
      i_retire = 1'b0;
      i_instr = HaltWord;
      tick("halt.take");
      chk("halt.ce_low", 64'(o_ce), 64'd0);
      chk("halt.in_drain", 64'(o_state), 64'd2);
      i_instr = NopWord;
      for (int i = 0; i < 3; i++) tick("halt.drain");
      chk("halt.not_done_yet", 64'(o_done), 64'd0);
      tick("halt.done");
      chk("halt.done", 64'(o_done), 64'd1);
      chk("halt.reason", 64'(o_reason), 64'd1);
      chk("halt.cycles", 64'(o_cycle_cnt), 64'd14);
      chk("halt.retired", 64'(o_retired_cnt), 64'd9);

      // Restart from DONE, then HALT held under stall
      i_start = 1'b1;
      tick("stall.restart");
      i_start = 1'b0;
      chk("stall.restart_cycles", 64'(o_cycle_cnt), 64'd0);
      chk("stall.restart_reason", 64'(o_reason), 64'd0);
      chk("stall.restart_state", 64'(o_state), 64'd1);
      tick("stall.run");
      i_instr = HaltWord;
      i_stall = 1'b1;
      tick("stall.hold1");
      tick("stall.hold2");
      chk("stall.still_run", 64'(o_state), 64'd1);
      i_stall = 1'b0;
      tick("stall.take");
      chk("stall.drain", 64'(o_state), 64'd2);
      i_instr = NopWord;
      run_to_done("stall.finish");

      // Priority: stop and HALT together
      i_start = 1'b1;
      tick("prio.start");
      i_start = 1'b0;
      tick("prio.run");
      i_stop = 1'b1;
      i_instr = HaltWord;
      tick("prio.take");
      chk("prio.reason", 64'(o_reason), 64'd1);
      quiet_inputs();
      run_to_done("prio.finish");

      // Reset at drain cycle 2
      i_start = 1'b1;
      tick("rst.start");
      i_start = 1'b0;
      tick("rst.run");
      i_stop = 1'b1;
      tick("rst.stop");
      i_stop = 1'b0;
      tick("rst.drain1");
      tick("rst.drain2");
      #1 d_rst = 1'b0;
      model_reset();
      #1;
      check_model("rst.async");
      chk("rst.busy_low", 64'(o_busy), 64'd0);
      @(negedge d_clk);
      d_rst = 1'b1;
      check_model("rst.release");

      // Start and stop together in IDLE
      i_start = 1'b1;
      i_stop = 1'b1;
      tick("ss.start");
      chk("ss.run", 64'(o_state), 64'd1);
      i_start = 1'b0;
      tick("ss.stop");
      chk("ss.reason", 64'(o_reason), 64'd2);
      i_stop = 1'b0;
      run_to_done("ss.finish");

      // Watchdog
      i_start = 1'b1;
      tick("wd.start");
      i_start = 1'b0;
      run_to_done("wd.finish");
      chk("wd.reason", 64'(o_reason), 64'd3);
      chk("wd.cycles", 64'(o_cycle_cnt), 64'(MaxCyc + DrainCyc));

`ifdef PIPE_STEP_EN
      // Single step: three pulses give three one-cycle fetch enables
      i_step_mode = 1'b1;
      i_start = 1'b1;
      tick("step.start");
      i_start = 1'b0;
      chk("step.pause", 64'(o_state), 64'd4);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         i_step = 1'b1;
         tick("step.pulse");
         if (o_ce) pulses++;
         i_step = 1'b0;
         tick("step.back");
         if (o_ce) pulses++;
         tick("step.gap");
         if (o_ce) pulses++;
      end
      chk("step.pulses", 64'(pulses), 64'd3);
      chk("step.cycles", 64'(o_cycle_cnt), 64'd3);
      i_step_mode = 1'b0;
      tick("step.resume");
      i_stop = 1'b1;
      tick("step.stop");
      i_stop = 1'b0;
      run_to_done("step.finish");
`else
      // Step mode select has no effect in this build
      pulses = 0;
      i_step_mode = 1'b1;
      i_start = 1'b1;
      tick("nostep.start");
      i_start = 1'b0;
      chk("nostep.run", 64'(o_state), 64'd1);
      i_step = 1'b1;
      tick("nostep.step");
      if (o_ce) pulses++;
      chk("nostep.ce_cont", 64'(pulses), 64'd1);
      i_step = 1'b0;
      i_step_mode = 1'b0;
      i_stop = 1'b1;
      tick("nostep.stop");
      i_stop = 1'b0;
      run_to_done("nostep.finish");
`endif

      // Random traffic
      for (int n = 0; n < 600; n++) begin
         i_start = ($urandom_range(0, 9) == 0);
         i_stop = ($urandom_range(0, 39) == 0);
         i_instr_valid = ($urandom_range(0, 3) != 0);
         i_instr = ($urandom_range(0, 11) == 0) ? HaltWord : $urandom;
         i_stall = ($urandom_range(0, 3) == 0);
         i_retire = $urandom_range(0, 1) == 1;
         i_step = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) i_step_mode = ~i_step_mode;
         tick("rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pipe_run_ctrl.md
# pipe_run_ctrl

Run controller for the 5-stage MIPS pipeline datapath. It generates the fetch-enable (`d_i_ce`) that starts, stops and drains the pipeline. It detects a HALT instruction in the decode register and enforces a cycle watchdog. It also keeps cycle and retired-instruction counters for the bench and debug host.

## Interface
Parameters:
- `HALT_INSTR`, 32'h0000000C: instruction word (SYSCALL encoding) that ends a run.
- `DRAIN_CYCLES`, 4: cycles with fetch disabled before DONE, enough for in-flight instructions to reach writeback. Legal range 1..15.
- `MAX_CYCLES`, 32'd100000: watchdog limit on RUN-state cycles.
- `CNT_WIDTH`, 32: width of both counters.

Ports:
- `d_clk`  in  1  clock.
- `d_rst`  in  1  reset, asynchronous, active-low.
- `i_start`  in  1  start pulse; honoured in IDLE and DONE.
- `i_stop`  in  1  abort request from host.
- `i_step_mode`  in  1  single-step mode select (used only with `PIPE_STEP_EN`).
- `i_step`  in  1  step pulse (used only with `PIPE_STEP_EN`).
- `i_instr`  in  32  instruction held in the IF/ID register.
- `i_instr_valid`  in  1  IF/ID register valid (ce).
- `i_stall`  in  1  load-use stall from the forwarding unit.
- `i_retire`  in  1  writeback of a valid instruction this cycle.
- `o_ce`  out  1  fetch enable; drives the datapath `d_i_ce`.
- `o_busy`  out  1  state is not IDLE and not DONE.
- `o_done`  out  1  state is DONE.
- `o_reason`  out  2  end cause: 0 none, 1 halt, 2 stop, 3 timeout.
- `o_state`  out  3  encoded state for debug.
- `o_cycle_cnt`  out  CNT_WIDTH  cycles spent in RUN/STEP/DRAIN.
- `o_retired_cnt`  out  CNT_WIDTH  `i_retire` pulses counted in RUN/STEP/PAUSE/DRAIN.

## Operation
State encoding: IDLE=0, RUN=1, DRAIN=2, DONE=3, PAUSE=4, STEP=5. Outputs are decoded from registered state only; none are combinational from inputs.
- **Outputs per state:**
  - `o_ce` = 1 in RUN and STEP only.
  - `o_busy` = 1 in RUN, PAUSE, STEP and DRAIN.
  - `o_done` = 1 in DONE.
- **IDLE:**
  - `i_start` moves to RUN (or to PAUSE with step mode active).
  - Entry from IDLE clears both counters, `o_reason` and the drain counter.
- **RUN:** end conditions, with priority halt > stop > timeout. Any end condition moves to DRAIN and latches `o_reason`.
  - Halt: `i_instr_valid && !i_stall && i_instr == HALT_INSTR`.
  - Stop: `i_stop`.
  - Timeout: `o_cycle_cnt == MAX_CYCLES-1`.
- **Halt shadow:** the instructions already fetched behind a HALT (at most 2: the PC/IMEM register and the IMEM output) still execute. This is architectural; the software places NOPs after HALT.
- **DRAIN:**
  - A 4-bit counter runs from 0 to `DRAIN_CYCLES-1`, then the block enters DONE.
  - `i_stop`, `i_start` and HALT are ignored.
- **DONE:**
  - Counters and `o_reason` are frozen.
  - `i_start` moves to RUN and clears the counters and `o_reason`. The PC is not reset; fetch resumes at the held PC.
- **Counters:** both saturate at all-ones and never wrap. `o_cycle_cnt` increments on each cycle spent in RUN, STEP or DRAIN.
- **Simultaneous `i_start` and `i_stop` in IDLE:** `i_start` wins and the block enters RUN. `i_stop` is sampled again on the first RUN cycle.
- **Reset:** `d_rst` low at any time, including mid-run or mid-drain:
  - The state goes to IDLE immediately.
  - All outputs go to 0: `o_ce`, `o_busy`, `o_done`, `o_reason`, `o_state`, both counters.

## Timing
- `i_start` sampled at edge N gives RUN and `o_ce`=1 from cycle N+1.
- End condition sampled at edge N:
  - DRAIN and `o_ce`=0 from N+1.
  - `o_done`=1 from N+1+`DRAIN_CYCLES`.
- HALT that coincides with `i_stall`=1 is not taken. It is taken on the first non-stalled cycle in which it is still in IF/ID.
- The cycle that samples an end condition counts as a RUN cycle in `o_cycle_cnt`.

## Configuration
`PIPE_STEP_EN`:
- **Defined:**
  - `i_start` with `i_step_mode`=1 enters PAUSE (`o_ce`=0).
  - In PAUSE, each `i_step` pulse gives STEP: `o_ce`=1 for exactly one cycle, then back to PAUSE. `i_step` held high steps every other cycle.
  - In RUN, `i_step_mode`=1 moves to PAUSE. In PAUSE, `i_step_mode`=0 resumes RUN.
  - Halt and stop are evaluated in STEP and PAUSE with the same priority as in RUN.
  - The watchdog counts RUN cycles only.
- **Undefined:** the `i_step_mode` and `i_step` ports exist but are ignored. PAUSE and STEP are unreachable.

## Test plan
- **Halt:** reset, pulse `i_start`; at cycle 10 present `i_instr`=32'h0000000C, valid, no stall. Expect `o_ce` low at cycle 11, `o_done` at cycle 15 (`DRAIN_CYCLES`=4), `o_reason`=1, `o_cycle_cnt`=14.
- **Stalled halt:** HALT present with `i_stall`=1 for 2 cycles, then `i_stall`=0. Expect DRAIN entered only after the non-stalled cycle.
- **Watchdog:** `MAX_CYCLES`=20 with no halt. Expect `o_reason`=3, DRAIN entered after `o_cycle_cnt` reaches 19, `o_done` 4 cycles later.
- **Priority:** `i_stop` and HALT in the same cycle give `o_reason`=1. In DONE, `i_start` clears the counters and restarts RUN.
- **Reset mid-drain:** drop `d_rst` at drain cycle 2. Expect all outputs 0 and state IDLE without waiting for a clock edge.
- **Single step (`PIPE_STEP_EN`):** `i_step_mode`=1, start, 3 `i_step` pulses. Expect exactly 3 single-cycle `o_ce` pulses and `o_cycle_cnt`=3.
